fft_filter_seq: RTL and testbench
=================================

# fft_filter_seq

Frame sequencer for the FFT → complex-multiply → IFFT filtering chain. It configures both transform cores once per frame, gates one N-sample ADC frame into the forward FFT, and generates coefficient-RAM read addresses aligned to FFT output bins. It also produces the multiplier and IFFT input valid/last strobes through matched delay lines, then waits for the IFFT output frame and pulses `done`. It sits beside the datapath in the `fft_clk` domain and replaces the free-running tvalid/aresetn gating.

## Interface
Parameters:
- `N_LOG2`, 10, log2 frame length (N = 1024)
- `RAM_LAT`, 2, coefficient RAM read latency, cycles
- `CMPY_LAT`, 6, complex multiplier latency, cycles

Ports:
- `fft_clk` in 1: the only clock
- `sys_rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: level input; a rising edge requests one frame
- `busy` out 1: high from the accepted start until `done`
- `done` out 1: one-cycle pulse when the IFFT output frame completes
- `err` out 1: sticky frame error; cleared on the next accepted start
- `fft_cfg_tdata` out 8: constant 8'h01 (forward)
- `fft_cfg_tvalid` out 1: forward-FFT config valid
- `fft_cfg_tready` in 1: forward-FFT config ready
- `ifft_cfg_tdata` out 8: constant 8'h00 (inverse)
- `ifft_cfg_tvalid` out 1: IFFT config valid
- `ifft_cfg_tready` in 1: IFFT config ready
- `fft_s_tvalid` out 1: ADC sample stream valid into the FFT
- `fft_s_tlast` out 1: last ADC sample of the frame
- `fft_s_tready` in 1: FFT input ready
- `fft_m_tvalid` in 1: FFT output bin valid (the FFT's m_tready is tied to 1)
- `fft_m_tlast` in 1: last FFT output bin
- `coef_rd_en` out 1: coefficient RAM read enable
- `coef_addr` out N_LOG2: coefficient RAM bin address
- `cmpy_tvalid` out 1: FFT output valid delayed by RAM_LAT, aligned with coefficient data
- `ifft_s_tvalid` out 1: product stream valid into the IFFT
- `ifft_s_tlast` out 1: last product of the frame
- `ifft_s_tready` in 1: IFFT input ready
- `ifft_m_tvalid` in 1: IFFT output valid
- `ifft_m_tlast` in 1: last IFFT output sample

## Operation
- States: IDLE → CFG → LOAD → XFORM → DRAIN → DONE → IDLE.
- IDLE:
  - `start` is registered once; a rising edge (start=1, prev=0) moves to CFG, clears `err`, sets `busy`.
  - Holding `start` high never retriggers a frame. Edges seen while busy are ignored.
- CFG:
  - Both cfg_tvalid outputs rise together. Each falls on its own handshake.
  - Leave CFG the cycle after both handshakes have completed, in any order.
- LOAD:
  - `fft_s_tvalid`=1. `samp_cnt` advances only on tvalid&&tready.
  - `fft_s_tlast`=1 when `samp_cnt`==N-1.
  - On the handshake with tlast: tvalid drops and the state moves to XFORM.
- XFORM:
  - `coef_rd_en` = `fft_m_tvalid`. `coef_addr` = `bin_cnt`, combinational from the registered counter.
  - `bin_cnt` increments on `fft_m_tvalid` and wraps to 0 after N-1.
  - A valid delay line of depth RAM_LAT produces `cmpy_tvalid`.
  - A further CMPY_LAT stages, carrying valid and last, produce `ifft_s_tvalid`/`ifft_s_tlast`.
  - Move to DRAIN when the delayed last exits the pipeline.
- DRAIN: count `ifft_m_tvalid` beats; on `ifft_m_tlast` → DONE.
- DONE: `done`=1 for one cycle, `busy`=0, → IDLE.
- Errors (all set `err`; the frame still runs to completion):
  - `fft_m_tlast` with `bin_cnt`≠N-1.
  - `fft_m_tlast` missing at `bin_cnt`==N-1.
  - `ifft_s_tvalid`=1 while `ifft_s_tready`=0. The chain has no skid buffer, so this beat is lost.
  - `ifft_m_tlast` count mismatch.
- `fft_m_tvalid` outside XFORM is ignored and sets `err`.

## Timing
- Reset values:
  - All outputs 0, except `fft_cfg_tdata`=8'h01 and `ifft_cfg_tdata`=8'h00.
  - State IDLE; all counters and delay lines cleared.
- Asynchronous reset mid-frame aborts immediately, with no `done`.
- Start edge at cycle t → `busy` and both cfg_tvalid high at t+1.
- Ready tied high and cfg accepted at t+1 → `fft_s_tvalid` from t+2 through t+N+1. `fft_s_tlast` is high at t+N+1.
- `cmpy_tvalid` = `fft_m_tvalid` delayed exactly RAM_LAT cycles.
- `ifft_s_tvalid` = `fft_m_tvalid` delayed exactly RAM_LAT+CMPY_LAT cycles.
- `done` is asserted 1 cycle after the cycle in which `ifft_m_tlast` and `ifft_m_tvalid` are both high.
- `busy` falls in the same cycle as `done`.

## Structure
- Shared package `fft_filter_pkg`:
  - state encoding
  - `FFT_CFG_FWD`=8'h01, `FFT_CFG_INV`=8'h00
  - default N_LOG2/latency constants
- One sub-module, `valid_delay`: parameterised-depth shift register carrying {valid, last}, with async clear. Instantiated twice (depth RAM_LAT, then depth CMPY_LAT).

## Test plan
- Nominal frame:
  - Stimulus: N=16 build; all readies tied 1; start pulse; FFT model returns 16 bins with tlast on the 16th.
  - Required: exactly 16 `fft_s` beats, tlast on the 16th; `coef_addr` 0..15.
  - Required: `ifft_s_tvalid` 8 cycles after each bin; one `done`; `err`=0.
- Backpressure:
  - Stimulus: `fft_s_tready` toggles 1/0 during LOAD.
  - Required: exactly 16 handshakes; tvalid held while ready is low; tlast only on the 16th accepted beat.
- Config order:
  - Stimulus: `ifft_cfg_tready` 3 cycles before `fft_cfg_tready`.
  - Required: each tvalid drops after its own handshake; LOAD begins the cycle after the later handshake.
- Start misuse:
  - Stimulus: `start` held high for 100 cycles; a second edge mid-frame.
  - Required: exactly one frame and one `done`.
- Errors:
  - Stimulus: early `fft_m_tlast` at bin 9.
  - Required: `err`=1 and sticky through `done`; cleared at the next start.
  - Stimulus: `ifft_s_tready`=0 during a valid beat.
  - Required: `err`=1.
- Reset mid-frame:
  - Stimulus: `sys_rst_n` low during XFORM.
  - Required: all outputs at their reset values immediately, no `done`; the next start runs a clean frame.

Source files
------------

// File: rtl/fft_filter_seq_pkg.sv
// fft_filter_pkg: shared types and constants for the FFT filter frame sequencer.
//   state_e        - sequencer FSM encoding
//   FFT_CFG_FWD/INV - transform-core config words (forward / inverse)
//   DEF_*          - default frame size and pipeline latencies
package fft_filter_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LOAD, S_XFORM, S_DRAIN, S_DONE
  } state_e;

  localparam logic [7:0] FFT_CFG_FWD = 8'h01;
  localparam logic [7:0] FFT_CFG_INV = 8'h00;

  localparam int DEF_N_LOG2   = 10;
  localparam int DEF_RAM_LAT  = 2;
  localparam int DEF_CMPY_LAT = 6;
endpackage

// File: rtl/fft_filter_seq_if.sv
// fft_filter_seq_if: streaming/config handshakes between the frame sequencer
// and the FFT -> coefficient RAM -> complex multiply -> IFFT datapath.
//   master: sequencer side (drives valids, cfg words, coef address)
//   slave : datapath side (drives readies and transform-core output strobes)
interface fft_filter_seq_if #(parameter int N_LOG2 = 10);
  logic [7:0]        fft_cfg_tdata;
  logic              fft_cfg_tvalid;
  logic              fft_cfg_tready;
  logic [7:0]        ifft_cfg_tdata;
  logic              ifft_cfg_tvalid;
  logic              ifft_cfg_tready;
  logic              fft_s_tvalid;
  logic              fft_s_tlast;
  logic              fft_s_tready;
  logic              fft_m_tvalid;
  logic              fft_m_tlast;
  logic              coef_rd_en;
  logic [N_LOG2-1:0] coef_addr;
  logic              cmpy_tvalid;
  logic              ifft_s_tvalid;
  logic              ifft_s_tlast;
  logic              ifft_s_tready;
  logic              ifft_m_tvalid;
  logic              ifft_m_tlast;

  modport master (
    output fft_cfg_tdata, fft_cfg_tvalid, ifft_cfg_tdata, ifft_cfg_tvalid,
           fft_s_tvalid, fft_s_tlast, coef_rd_en, coef_addr, cmpy_tvalid,
           ifft_s_tvalid, ifft_s_tlast,
    input  fft_cfg_tready, ifft_cfg_tready, fft_s_tready, fft_m_tvalid,
           fft_m_tlast, ifft_s_tready, ifft_m_tvalid, ifft_m_tlast
  );

  modport slave (
    input  fft_cfg_tdata, fft_cfg_tvalid, ifft_cfg_tdata, ifft_cfg_tvalid,
           fft_s_tvalid, fft_s_tlast, coef_rd_en, coef_addr, cmpy_tvalid,
           ifft_s_tvalid, ifft_s_tlast,
    output fft_cfg_tready, ifft_cfg_tready, fft_s_tready, fft_m_tvalid,
           fft_m_tlast, ifft_s_tready, ifft_m_tvalid, ifft_m_tlast
  );
endinterface

// File: rtl/fft_filter_seq_valid_delay.sv
// valid_delay: fixed-depth shift register carrying {valid, last}.
//   clk, rst_n (async, active-low clear), i_vld/i_last in,
//   o_vld/o_last = inputs delayed by exactly STAGES cycles (STAGES >= 1).
module valid_delay
  import fft_filter_pkg::*;
#(
  parameter int STAGES = DEF_RAM_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_last,
  output logic o_vld,
  output logic o_last
);
  logic [STAGES:1] r_vld_pipe;
  logic [STAGES:1] r_last_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe[1]  <= i_vld;
      r_last_pipe[1] <= i_last;
      for (int k = 2; k <= STAGES; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_last_pipe[k] <= r_last_pipe[k-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[STAGES];
  assign o_last = r_last_pipe[STAGES];
endmodule

// File: rtl/fft_filter_seq.sv
// fft_filter_seq: per-frame sequencer for the FFT -> cmpy -> IFFT filter chain.
//   fft_clk, sys_rst_n (async, active-low)
//   start (level; rising edge requests a frame), busy, done (1-cycle), err (sticky)
//   bus (master): cfg handshakes for both cores, ADC frame gating into the FFT,
//   coefficient RAM addressing, cmpy/IFFT valid+last strobes, IFFT output watch.
module fft_filter_seq
  import fft_filter_pkg::*;
#(
  parameter int N_LOG2   = DEF_N_LOG2,
  parameter int RAM_LAT  = DEF_RAM_LAT,
  parameter int CMPY_LAT = DEF_CMPY_LAT
) (
  input  logic              fft_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  fft_filter_seq_if.master  bus
);
  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  state_e            r_state, w_state_nx;
  logic              r_start_d, r_fft_cfg_pend, r_ifft_cfg_pend, r_err;
  logic [N_LOG2-1:0] r_samp_cnt, r_bin_cnt, r_out_cnt;

  logic w_start_edge, w_accept, w_fft_cfg_hs, w_ifft_cfg_hs, w_cfg_done;
  logic w_samp_hs, w_bin_beat, w_out_beat, w_err_set;
  logic w_busy, w_done, w_fft_s_tvalid, w_fft_s_tlast, w_coef_rd_en;
  logic w_cmpy_vld, w_cmpy_last, w_ifft_vld, w_ifft_last;

  assign w_start_edge  = start & ~r_start_d;
  assign w_accept      = (r_state == S_IDLE) & w_start_edge;
  assign w_fft_cfg_hs  = r_fft_cfg_pend & bus.fft_cfg_tready;
  assign w_ifft_cfg_hs = r_ifft_cfg_pend & bus.ifft_cfg_tready;
  // Both handshakes may land in either order or in the same cycle.
  assign w_cfg_done    = (~r_fft_cfg_pend | w_fft_cfg_hs) &
                         (~r_ifft_cfg_pend | w_ifft_cfg_hs);
  assign w_samp_hs     = (r_state == S_LOAD) & bus.fft_s_tready;
  assign w_bin_beat    = (r_state == S_XFORM) & bus.fft_m_tvalid;
  assign w_out_beat    = (r_state == S_DRAIN) & bus.ifft_m_tvalid;

  // Any of these flags the frame but never stalls it.
  assign w_err_set =
      (bus.fft_m_tvalid & (r_state != S_XFORM))
    | (w_bin_beat & (bus.fft_m_tlast != (r_bin_cnt == LAST_IDX)))
    | (w_ifft_vld & ~bus.ifft_s_tready)  // no skid buffer: beat is lost
    | (w_out_beat & (bus.ifft_m_tlast != (r_out_cnt == LAST_IDX)));

  always_ff @(posedge fft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_busy         = 1'b0;
    w_done         = 1'b0;
    w_fft_s_tvalid = 1'b0;
    w_fft_s_tlast  = 1'b0;
    w_coef_rd_en   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nx = S_CFG;
      S_CFG: begin
        w_busy = 1'b1;
        if (w_cfg_done) w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        w_busy         = 1'b1;
        w_fft_s_tvalid = 1'b1;
        w_fft_s_tlast  = (r_samp_cnt == LAST_IDX);
        if (w_samp_hs && w_fft_s_tlast) w_state_nx = S_XFORM;
      end
      S_XFORM: begin
        w_busy       = 1'b1;
        w_coef_rd_en = bus.fft_m_tvalid;
        // Stay until the frame's last product has left the multiplier.
        if (w_ifft_vld && w_ifft_last) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (bus.ifft_m_tvalid && bus.ifft_m_tlast) w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_done     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge fft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_start_d       <= 1'b0;
      r_fft_cfg_pend  <= 1'b0;
      r_ifft_cfg_pend <= 1'b0;
      r_err           <= 1'b0;
      r_samp_cnt      <= '0;
      r_bin_cnt       <= '0;
      r_out_cnt       <= '0;
    end else begin
      // Tracked every cycle so edges during a frame are consumed, not queued.
      r_start_d <= start;
      if (w_accept) begin
        r_fft_cfg_pend  <= 1'b1;
        r_ifft_cfg_pend <= 1'b1;
        r_err           <= 1'b0;
        r_samp_cnt      <= '0;
        r_bin_cnt       <= '0;
        r_out_cnt       <= '0;
      end else begin
        if (w_fft_cfg_hs)  r_fft_cfg_pend  <= 1'b0;
        if (w_ifft_cfg_hs) r_ifft_cfg_pend <= 1'b0;
        if (w_err_set)     r_err           <= 1'b1;
        if (w_samp_hs)     r_samp_cnt      <= r_samp_cnt + 1'b1;
        if (w_bin_beat)    r_bin_cnt       <= r_bin_cnt + 1'b1;  // wraps at N
        if (w_out_beat)    r_out_cnt       <= r_out_cnt + 1'b1;
      end
    end
  end

  // RAM read latency, then multiplier latency, so strobes line up with data.
  valid_delay #(.STAGES(RAM_LAT)) u_ram_dly (
    .clk   (fft_clk),
    .rst_n (sys_rst_n),
    .i_vld (bus.fft_m_tvalid),
    .i_last(bus.fft_m_tvalid & bus.fft_m_tlast),
    .o_vld (w_cmpy_vld),
    .o_last(w_cmpy_last)
  );

  valid_delay #(.STAGES(CMPY_LAT)) u_cmpy_dly (
    .clk   (fft_clk),
    .rst_n (sys_rst_n),
    .i_vld (w_cmpy_vld),
    .i_last(w_cmpy_last),
    .o_vld (w_ifft_vld),
    .o_last(w_ifft_last)
  );

  assign busy                = w_busy;
  assign done                = w_done;
  assign err                 = r_err;
  assign bus.fft_cfg_tdata   = FFT_CFG_FWD;
  assign bus.ifft_cfg_tdata  = FFT_CFG_INV;
  assign bus.fft_cfg_tvalid  = r_fft_cfg_pend;
  assign bus.ifft_cfg_tvalid = r_ifft_cfg_pend;
  assign bus.fft_s_tvalid    = w_fft_s_tvalid;
  assign bus.fft_s_tlast     = w_fft_s_tlast;
  assign bus.coef_rd_en      = w_coef_rd_en;
  assign bus.coef_addr       = r_bin_cnt;
  assign bus.cmpy_tvalid     = w_cmpy_vld;
  assign bus.ifft_s_tvalid   = w_ifft_vld;
  assign bus.ifft_s_tlast    = w_ifft_last;
endmodule

// File: tb/tb_fft_filter_seq.sv
// tb_fft_filter_seq: directed bench for fft_filter_seq built with N=16.
module tb_fft_filter_seq;
  import fft_filter_pkg::*;

  localparam int NL = 4;
  localparam int N  = 16;
  localparam int RL = 2;
  localparam int CL = 6;

  logic fft_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic start     = 1'b0;
  logic busy, done, err;

  fft_filter_seq_if #(.N_LOG2(NL)) bus ();

  fft_filter_seq #(.N_LOG2(NL), .RAM_LAT(RL), .CMPY_LAT(CL)) dut (
    .fft_clk  (fft_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  always #5 fft_clk = ~fft_clk;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;
  logic [15:0] vh, lh;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference history of FFT output strobes, one bit per past cycle.
  always @(posedge fft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vh <= '0;
      lh <= '0;
    end else begin
      vh <= {vh[14:0], bus.fft_m_tvalid};
      lh <= {lh[14:0], bus.fft_m_tvalid & bus.fft_m_tlast};
    end
  end

  always @(posedge fft_clk) if (done) done_cnt <= done_cnt + 1;

  always @(negedge fft_clk) begin
    if (mon_en && sys_rst_n) begin
      #2;
      chk1("cmpy_tvalid delay", bus.cmpy_tvalid, vh[RL-1]);
      chk1("ifft_s_tvalid delay", bus.ifft_s_tvalid, vh[RL+CL-1]);
      chk1("ifft_s_tlast delay", bus.ifft_s_tlast, lh[RL+CL-1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic st, fcr, icr, str;
    logic bsy, fcv, icv, sv, sl;
  } vec_t;
  vec_t tbl [8];

  task automatic idle(input int n);
    repeat (n) @(negedge fft_clk);
  endtask

  task automatic start_frame();
    @(negedge fft_clk);
    start = 1'b1; bus.fft_cfg_tready = 1'b1; bus.ifft_cfg_tready = 1'b1;
    #1 chk1("pre-start busy", busy, 1'b0);
    @(negedge fft_clk);
    start = 1'b0;
    #1;
    chk1("start busy", busy, 1'b1);
    chk1("start fft cfg valid", bus.fft_cfg_tvalid, 1'b1);
    chk1("start ifft cfg valid", bus.ifft_cfg_tvalid, 1'b1);
    chk1("start err cleared", err, 1'b0);
  endtask

  task automatic run_load(input bit toggle);
    int hs;
    hs = 0;
    for (int c = 0; c < 100 && hs < N; c++) begin
      @(negedge fft_clk);
      bus.fft_s_tready = toggle ? c[0] : 1'b1;
      #1;
      chk1("load tvalid", bus.fft_s_tvalid, 1'b1);
      chk1("load tlast", bus.fft_s_tlast, hs == N-1);
      if (bus.fft_s_tready) hs++;
    end
    chkv("load handshakes", hs, N);
    @(negedge fft_clk);
    bus.fft_s_tready = 1'b1;
    #1 chk1("tvalid after last", bus.fft_s_tvalid, 1'b0);
  endtask

  task automatic run_bins(input int early);
    for (int b = 0; b < N; b++) begin
      @(negedge fft_clk);
      bus.fft_m_tvalid = 1'b1;
      bus.fft_m_tlast  = (b == N-1) || (b == early);
      #1;
      chk1("coef_rd_en", bus.coef_rd_en, 1'b1);
      chkv("coef_addr", 32'(bus.coef_addr), b);
    end
    @(negedge fft_clk);
    bus.fft_m_tvalid = 1'b0;
    bus.fft_m_tlast  = 1'b0;
    #1 chk1("coef_rd_en idle", bus.coef_rd_en, 1'b0);
  endtask

  task automatic run_ifft();
    for (int i = 0; i < N; i++) begin
      @(negedge fft_clk);
      bus.ifft_m_tvalid = 1'b1;
      bus.ifft_m_tlast  = (i == N-1);
      #1;
      chk1("drain busy", busy, 1'b1);
      chk1("drain done", done, 1'b0);
    end
    @(negedge fft_clk);
    bus.ifft_m_tvalid = 1'b0;
    bus.ifft_m_tlast  = 1'b0;
    #1;
    chk1("done pulse", done, 1'b1);
    chk1("busy low at done", busy, 1'b0);
    @(negedge fft_clk);
    #1 chk1("done one cycle", done, 1'b0);
  endtask

  initial begin
    //           st fcr icr str  bsy fcv icv sv sl
    tbl[0] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[3] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[4] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[5] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[6] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0};

    bus.fft_cfg_tready  = 1'b0;
    bus.ifft_cfg_tready = 1'b0;
    bus.fft_s_tready    = 1'b1;
    bus.fft_m_tvalid    = 1'b0;
    bus.fft_m_tlast     = 1'b0;
    bus.ifft_s_tready   = 1'b1;
    bus.ifft_m_tvalid   = 1'b0;
    bus.ifft_m_tlast    = 1'b0;

    // Reset state
    #1;
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst err", err, 1'b0);
    chkv("rst fft cfg data", 32'(bus.fft_cfg_tdata), 32'h01);
    chkv("rst ifft cfg data", 32'(bus.ifft_cfg_tdata), 32'h00);
    chk1("rst fft_s_tvalid", bus.fft_s_tvalid, 1'b0);
    chk1("rst ifft_s_tvalid", bus.ifft_s_tvalid, 1'b0);
    repeat (3) @(negedge fft_clk);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;

    // Frame A: config order table, start held high ~100 cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge fft_clk);
      start               = tbl[i].st;
      bus.fft_cfg_tready  = tbl[i].fcr;
      bus.ifft_cfg_tready = tbl[i].icr;
      bus.fft_s_tready    = tbl[i].str;
      #1;
      chk1($sformatf("row%0d busy", i), busy, tbl[i].bsy);
      chk1($sformatf("row%0d fft_cfg_tvalid", i), bus.fft_cfg_tvalid, tbl[i].fcv);
      chk1($sformatf("row%0d ifft_cfg_tvalid", i), bus.ifft_cfg_tvalid, tbl[i].icv);
      chk1($sformatf("row%0d fft_s_tvalid", i), bus.fft_s_tvalid, tbl[i].sv);
      chk1($sformatf("row%0d fft_s_tlast", i), bus.fft_s_tlast, tbl[i].sl);
    end
    run_load(1'b0);
    run_bins(-1);
    idle(10);
    run_ifft();
    chk1("frame A err", err, 1'b0);
    idle(40);
    #1;
    chk1("held start no retrigger", busy, 1'b0);
    chkv("frame A done count", done_cnt, 1);
    start = 1'b0;

    // Frame B: input backpressure, extra start edge mid-frame
    start_frame();
    run_load(1'b1);
    run_bins(-1);
    @(negedge fft_clk);
    start = 1'b1;
    idle(10);
    run_ifft();
    idle(5);
    #1;
    chk1("mid-frame edge ignored", busy, 1'b0);
    chkv("frame B done count", done_cnt, 2);
    chk1("frame B err", err, 1'b0);
    start = 1'b0;

    // Frame C: early fft_m_tlast at bin 9
    start_frame();
    run_load(1'b0);
    run_bins(9);
    #1 chk1("early tlast err", err, 1'b1);
    idle(10);
    run_ifft();
    chk1("err sticky after done", err, 1'b1);
    chkv("frame C done count", done_cnt, 3);

    // Frame D: err cleared by start, then IFFT input stall
    start_frame();
    run_load(1'b0);
    chk1("err before stall", err, 1'b0);
    bus.ifft_s_tready = 1'b0;
    run_bins(-1);
    idle(10);
    bus.ifft_s_tready = 1'b1;
    #1 chk1("ifft stall err", err, 1'b1);
    run_ifft();
    chkv("frame D done count", done_cnt, 4);

    // Frame E: reset during XFORM
    start_frame();
    run_load(1'b0);
    for (int b = 0; b < 5; b++) begin
      @(negedge fft_clk);
      bus.fft_m_tvalid = 1'b1;
    end
    @(negedge fft_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk1("mid rst busy", busy, 1'b0);
    chk1("mid rst done", done, 1'b0);
    chk1("mid rst err", err, 1'b0);
    chk1("mid rst fft cfg valid", bus.fft_cfg_tvalid, 1'b0);
    chk1("mid rst ifft cfg valid", bus.ifft_cfg_tvalid, 1'b0);
    chk1("mid rst fft_s_tvalid", bus.fft_s_tvalid, 1'b0);
    chk1("mid rst coef_rd_en", bus.coef_rd_en, 1'b0);
    chkv("mid rst coef_addr", 32'(bus.coef_addr), 0);
    chk1("mid rst cmpy_tvalid", bus.cmpy_tvalid, 1'b0);
    chk1("mid rst ifft_s_tvalid", bus.ifft_s_tvalid, 1'b0);
    chkv("mid rst fft cfg data", 32'(bus.fft_cfg_tdata), 32'h01);
    bus.fft_m_tvalid = 1'b0;
    idle(3);
    sys_rst_n = 1'b1;
    idle(20);
    #1;
    chkv("no done after reset", done_cnt, 4);
    chk1("idle after reset", busy, 1'b0);

    // Frame F: clean frame after reset
    start_frame();
    run_load(1'b0);
    run_bins(-1);
    idle(10);
    run_ifft();
    chk1("frame F err", err, 1'b0);
    chkv("frame F done count", done_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
